// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register file with multiply, iterative divide and MTHI/MTLO
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   alucontrol  5-bit ALU control code (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   valid_i     execute-stage instruction valid
//   flush_i     execute stage is being flushed
//   a, b        rs / rt operands
//   hi_o, lo_o  HI / LO register values
//   stall_o     combinational request to hold the execute stage
//
// Optional build macro: HILO_MULT_2CYCLE_EN registers the product and
// writes HI/LO one cycle later from the MUL_DONE state.
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  alucontrol,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stall_o
);

    localparam logic [4:0] MULT_CONTROL  = 5'b11000;
    localparam logic [4:0] MULTU_CONTROL = 5'b11001;
    localparam logic [4:0] DIV_CONTROL   = 5'b11010;
    localparam logic [4:0] DIVU_CONTROL  = 5'b11011;
    localparam logic [4:0] MTHI_CONTROL  = 5'b11100;
    localparam logic [4:0] MTLO_CONTROL  = 5'b11101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
`ifdef HILO_MULT_2CYCLE_EN
        ,
        MUL_DONE = 2'd3
`endif
    } state_t;

    state_t      state;
    logic [4:0]  iter_cnt;
    logic [31:0] dvd_q;      // dividend magnitude, becomes the quotient as bits shift in
    logic [31:0] dsr_q;      // divisor magnitude
    logic [31:0] rem_q;      // partial remainder
    logic        neg_quo;
    logic        neg_rem;
`ifdef HILO_MULT_2CYCLE_EN
    logic [63:0] prod_q;
`endif

    logic        is_mul, is_div, is_mthi, is_mtlo, is_signed, accept;
    logic [31:0] a_mag, b_mag;
    logic [63:0] a_ext, b_ext, product;
    logic [33:0] trial;
    logic [31:0] quo_res, rem_res;

    always_comb begin
        is_mul    = (alucontrol == MULT_CONTROL) || (alucontrol == MULTU_CONTROL);
        is_div    = (alucontrol == DIV_CONTROL)  || (alucontrol == DIVU_CONTROL);
        is_mthi   = (alucontrol == MTHI_CONTROL);
        is_mtlo   = (alucontrol == MTLO_CONTROL);
        is_signed = (alucontrol == MULT_CONTROL) || (alucontrol == DIV_CONTROL);
        accept    = valid_i && !flush_i && (state == IDLE) &&
                    (is_mul || is_div || is_mthi || is_mtlo);

        // Sign-extending both operands to 64 bits makes the truncated
        // 64-bit product correct for signed and unsigned alike.
        a_ext   = {{32{is_signed & a[31]}}, a};
        b_ext   = {{32{is_signed & b[31]}}, b};
        product = a_ext * b_ext;

        a_mag = (is_signed && a[31]) ? (32'd0 - a) : a;
        b_mag = (is_signed && b[31]) ? (32'd0 - b) : b;

        // One restoring step: shift the next dividend bit into the
        // remainder and try subtracting the divisor; bit 33 is the borrow.
        trial = {1'b0, rem_q, dvd_q[31]} - {2'b00, dsr_q};

        quo_res = neg_quo ? (32'd0 - dvd_q) : dvd_q;
        rem_res = neg_rem ? (32'd0 - rem_q) : rem_q;
    end

    always_comb begin
        stall_o = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
`ifdef HILO_MULT_2CYCLE_EN
                    stall_o = accept && (is_div || is_mul);
`else
                    stall_o = accept && is_div;
`endif
                end
                DIV_RUN: stall_o = !flush_i;
                default: stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
            iter_cnt <= 5'd0;
            dvd_q    <= 32'd0;
            dsr_q    <= 32'd0;
            rem_q    <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
`ifdef HILO_MULT_2CYCLE_EN
            prod_q   <= 64'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mthi) begin
                            hi_o <= a;
                        end else if (is_mtlo) begin
                            lo_o <= a;
                        end else if (is_mul) begin
`ifdef HILO_MULT_2CYCLE_EN
                            prod_q <= product;
                            state  <= MUL_DONE;
`else
                            hi_o <= product[63:32];
                            lo_o <= product[31:0];
`endif
                        end else begin
                            dvd_q    <= a_mag;
                            dsr_q    <= b_mag;
                            rem_q    <= 32'd0;
                            neg_quo  <= is_signed && (a[31] ^ b[31]);
                            neg_rem  <= is_signed && a[31];
                            iter_cnt <= 5'd0;
                            state    <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    if (flush_i) begin
                        iter_cnt <= 5'd0;
                        state    <= IDLE;
                    end else begin
                        if (!trial[33]) begin
                            rem_q <= trial[31:0];
                        end else begin
                            rem_q <= {rem_q[30:0], dvd_q[31]};
                        end
                        dvd_q    <= {dvd_q[30:0], !trial[33]};
                        iter_cnt <= iter_cnt + 5'd1;
                        if (iter_cnt == 5'd31) begin
                            state <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    // The divide instruction is still presented here; going
                    // straight back to IDLE without re-checking accept keeps
                    // it from being started a second time.
                    if (!flush_i) begin
                        lo_o <= quo_res;
                        hi_o <= rem_res;
                    end
                    iter_cnt <= 5'd0;
                    state    <= IDLE;
                end
`ifdef HILO_MULT_2CYCLE_EN
                MUL_DONE: begin
                    if (!flush_i) begin
                        hi_o <= prod_q[63:32];
                        lo_o <= prod_q[31:0];
                    end
                    state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
